// File: rtl/bcm_pkg.sv
// Shared definitions for the bit-code packer: code values, packer states and
// the helper that sizes the fill index and word-count fields.
package bcm_pkg;

    localparam logic [1:0] CODE_00 = 2'b00;
    localparam logic [1:0] CODE_01 = 2'b01;
    localparam logic [1:0] CODE_10 = 2'b10;
    localparam logic [1:0] CODE_11 = 2'b11;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Width needed to count 0..pairs codes.
    function automatic int cnt_width(input int pairs);
        return $clog2(pairs + 1);
    endfunction

endpackage

// File: rtl/bcm_hist_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module bcm_hist_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/bcm_packer.sv
// Packs PAIRS 2-bit mapper codes LSB-first into one word on a valid/ready output.
// Optional per-code histogram counters are built when BCM_PACKER_HIST_EN is defined.
module bcm_packer
    import bcm_pkg::*;
#(
    parameter int  PAIRS = 4,
    parameter int  CNT_W = 8,
    localparam int IW    = cnt_width(PAIRS)
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               in_valid,
    input  logic [1:0]         in_code,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    output logic [2*PAIRS-1:0] out_data,
    output logic [IW-1:0]      out_cnt,
    input  logic               out_ready,
    output logic               state_dbg
`ifdef BCM_PACKER_HIST_EN
    ,
    input  logic               hist_clr,
    output logic [CNT_W-1:0]   hist0,
    output logic [CNT_W-1:0]   hist1,
    output logic [CNT_W-1:0]   hist2,
    output logic [CNT_W-1:0]   hist3
`endif
);

    localparam int             WORD_W = 2 * PAIRS;
    localparam logic [IW-1:0]  LAST   = IW'(PAIRS - 1);

    if (PAIRS < 2 || PAIRS > 8 || CNT_W < 1) begin : g_bad_param
        $error("bcm_packer: PAIRS must be 2..8 and CNT_W at least 1");
    end

    // Handshake: a beat moves on a side only in a cycle where its valid and
    // ready are both high; ready never depends on valid of the same side.
    state_t              state_q, state_d;
    logic [WORD_W-1:0]   buf_q, buf_d, word, data_q, data_d;
    logic [IW-1:0]       idx_q, idx_d, idx_inc, cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic                in_xfer, out_xfer, complete, do_flush;

    // While a word is held the last free slot opens only if the held word leaves.
    assign in_ready  = (state_q == FILL) || (idx_q != LAST) || out_ready;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = (state_q == HOLD) && out_ready;
    assign complete  = in_xfer && (idx_q == LAST);
    assign idx_inc   = idx_q + IW'(in_xfer);
    assign word      = in_xfer ? (buf_q | (WORD_W'(in_code) << {idx_q, 1'b0})) : buf_q;

    assign out_valid = (state_q == HOLD);
    assign out_data  = data_q;
    assign out_cnt   = cnt_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        idx_d    = idx_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        do_flush = 1'b0;
        case (state_q)
            FILL: begin
                do_flush = (flush || pend_q) && (idx_inc != '0);
                pend_d   = 1'b0;
                if (complete || do_flush) begin
                    data_d  = word;
                    cnt_d   = complete ? IW'(PAIRS) : idx_inc;
                    buf_d   = {PAIRS{CODE_00}};
                    idx_d   = '0;
                    state_d = HOLD;
                end else if (in_xfer) begin
                    buf_d = word;
                    idx_d = idx_inc;
                end
            end
            HOLD: begin
                pend_d = pend_q || flush;
                // A completing beat here implies out_ready, so swap words without a bubble.
                if (complete) begin
                    data_d = word;
                    cnt_d  = IW'(PAIRS);
                    buf_d  = {PAIRS{CODE_00}};
                    idx_d  = '0;
                    pend_d = 1'b0;
                end else begin
                    if (in_xfer) begin
                        buf_d = word;
                        idx_d = idx_inc;
                    end
                    if (out_xfer) begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= FILL;
            buf_q   <= {PAIRS{CODE_00}};
            idx_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

`ifdef BCM_PACKER_HIST_EN
    bcm_hist_cnt #(.W(CNT_W)) u_hist0 (.clk(clk), .rst_b(rst_b), .clr(hist_clr),
        .inc(in_xfer && (in_code == CODE_00)), .cnt(hist0));
    bcm_hist_cnt #(.W(CNT_W)) u_hist1 (.clk(clk), .rst_b(rst_b), .clr(hist_clr),
        .inc(in_xfer && (in_code == CODE_01)), .cnt(hist1));
    bcm_hist_cnt #(.W(CNT_W)) u_hist2 (.clk(clk), .rst_b(rst_b), .clr(hist_clr),
        .inc(in_xfer && (in_code == CODE_10)), .cnt(hist2));
    bcm_hist_cnt #(.W(CNT_W)) u_hist3 (.clk(clk), .rst_b(rst_b), .clr(hist_clr),
        .inc(in_xfer && (in_code == CODE_11)), .cnt(hist3));
`endif

endmodule

// File: tb/tb_bcm_packer.sv
// Self-checking bench for bcm_packer: directed scenarios plus random traffic,
// words checked through an expected queue filled by a code-list reference model.
module tb_bcm_packer;

    localparam int PAIRS = 4;
    localparam int CNT_W = 2;
    localparam int IW    = $clog2(PAIRS + 1);
    localparam int DW    = 2 * PAIRS;
    localparam int W     = IW + DW;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          in_valid = 1'b0;
    logic [1:0]    in_code = 2'b00;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_cnt;
    logic          state_dbg;
`ifdef BCM_PACKER_HIST_EN
    logic             hist_clr = 1'b0;
    logic [CNT_W-1:0] hist0, hist1, hist2, hist3;
    int               hm[4];
`endif

    int         total = 0;
    int         bad = 0;
    int         words_seen = 0;
    logic [W-1:0] exp_q[$];
    int         part[$];
    bit         held = 1'b0;
    bit         pend = 1'b0;

    bcm_packer #(.PAIRS(PAIRS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_code(in_code),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_data(out_data), .out_cnt(out_cnt), .out_ready(out_ready),
        .state_dbg(state_dbg)
`ifdef BCM_PACKER_HIST_EN
        , .hist_clr(hist_clr), .hist0(hist0), .hist1(hist1), .hist2(hist2), .hist3(hist3)
`endif
    );

    // clock/reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: a word is the list of accepted codes, code k weighted by 4**k
    task automatic emit();
        int d;
        d = 0;
        for (int k = 0; k < part.size(); k++) d += part[k] * (4 ** k);
        exp_q.push_back({IW'(part.size()), DW'(d)});
        part.delete();
        held = 1'b1;
    endtask

    task automatic model_clear();
        part.delete();
        exp_q.delete();
        held = 1'b0;
        pend = 1'b0;
`ifdef BCM_PACKER_HIST_EN
        for (int n = 0; n < 4; n++) hm[n] = 0;
`endif
    endtask

    // driver: one cycle of stimulus, model prediction checked before the edge it describes
    task automatic step(input bit v, input logic [1:0] c, input bit f, input bit r);
        bit exp_rdy, xfer, fl;
        @(posedge clk);
        #2;
        in_valid = v; in_code = c; flush = f; out_ready = r;
        @(negedge clk);
        exp_rdy = !held || (part.size() < PAIRS - 1) || r;
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, held);
`ifdef BCM_PACKER_HIST_EN
        check("hist0", hist0, hm[0]);
        check("hist1", hist1, hm[1]);
        check("hist2", hist2, hm[2]);
        check("hist3", hist3, hm[3]);
        if (hist_clr) begin
            for (int n = 0; n < 4; n++) hm[n] = 0;
        end else if (v && exp_rdy && hm[c] < (2 ** CNT_W) - 1) begin
            hm[c]++;
        end
`endif
        xfer = v && exp_rdy;
        if (xfer) part.push_back(int'(c));
        if (held) begin
            if (f) pend = 1'b1;
            if (part.size() == PAIRS) begin
                emit();
                pend = 1'b0;
            end else if (r) begin
                held = 1'b0;
            end
        end else begin
            fl = f || pend;
            pend = 1'b0;
            if (part.size() == PAIRS) emit();
            else if (fl && part.size() > 0) emit();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_b = 1'b0; in_valid = 1'b0; flush = 1'b0;
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 1);
        check("rst out_data", out_data, 0);
        check("rst out_cnt", out_cnt, 0);
        model_clear();
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_b = 1'b1;
    endtask

    // scoreboard monitor: pops one expected word per output transfer
    always @(negedge clk) begin
        if (rst_b && out_valid && out_ready) begin
            words_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL word: got %0h/%0h, want no word", out_cnt, out_data);
            end else begin
                check("word", {21'd0, out_cnt, out_data}, {21'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int ws;
        do_reset();

        // four codes -> 0x39 one cycle after the last beat
        step(1, 2'd1, 0, 1); step(1, 2'd2, 0, 1); step(1, 2'd3, 0, 1); step(1, 2'd0, 0, 0);
        step(0, 2'd0, 0, 0);
        check("first valid", out_valid, 1);
        check("first data", out_data, 8'h39);
        check("first cnt", out_cnt, 4);

        // held word: three codes fit, the fourth stalls until out_ready
        step(1, 2'd1, 0, 0); step(1, 2'd2, 0, 0); step(1, 2'd3, 0, 0); step(1, 2'd0, 0, 0);
        check("stall in_ready", in_ready, 0);
        step(1, 2'd0, 0, 1);
        step(0, 2'd0, 0, 1);

        // partial flush, then flush of an empty buffer
        step(1, 2'd3, 0, 1); step(1, 2'd3, 0, 1); step(0, 2'd0, 1, 1);
        step(0, 2'd0, 0, 0);
        check("flush data", out_data, 8'h0F);
        check("flush cnt", out_cnt, 2);
        step(0, 2'd0, 0, 1); step(0, 2'd0, 1, 1); step(0, 2'd0, 0, 1);
        check("empty flush", out_valid, 0);

        // continuous stream of 12 codes
        ws = words_seen;
        for (int i = 0; i < 12; i++) step(1, 2'($urandom_range(0, 3)), 0, 1);
        step(0, 2'd0, 0, 1); step(0, 2'd0, 0, 1);
        check("stream words", words_seen - ws, 3);

        // reset mid-word and while holding
        step(1, 2'd1, 0, 1); step(1, 2'd1, 0, 1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 2'd2, 0, 0);
        step(0, 2'd0, 0, 0);
        check("held before rst", out_valid, 1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 2'(i), 0, 1);
        step(0, 2'd0, 0, 0);
        check("fresh data", out_data, 8'hE4);
        check("fresh cnt", out_cnt, 4);
        step(0, 2'd0, 0, 1);

`ifdef BCM_PACKER_HIST_EN
        hist_clr = 1'b1; step(0, 2'd0, 0, 1); hist_clr = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 2'd2, 0, 1);
        step(0, 2'd0, 0, 1);
        check("hist2 sat", hist2, 3);
        hist_clr = 1'b1; step(1, 2'd2, 0, 1); hist_clr = 1'b0;
        step(0, 2'd0, 0, 1);
        check("hist clr", {hist0, hist1, hist2, hist3}, 0);
`endif

        // random traffic
        for (int i = 0; i < 600; i++) begin
`ifdef BCM_PACKER_HIST_EN
            hist_clr = ($urandom_range(0, 31) == 0);
`endif
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        end
`ifdef BCM_PACKER_HIST_EN
        hist_clr = 1'b0;
`endif
        step(0, 2'd0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 2'd0, 0, 1);
        check("queue empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
